// File: rtl/fp_normalize_round_if.sv
// Beat bus between the FP add front end and the normalize/round back end.
// The producer uses the master modport; fp_normalize_round uses the slave modport.
interface fp_normalize_round_if #(
    parameter int LANES = 16
);
    logic                  in_valid;
    logic [1:0]            in_thread_idx;
    logic [LANES-1:0]      in_mask;
    logic [LANES*28-1:0]   in_sum;
    logic [LANES*8-1:0]    in_exponent;
    logic [LANES-1:0]      in_sign;
    logic [LANES-1:0]      in_is_inf;
    logic [LANES-1:0]      in_is_nan;

    logic                  out_valid;
    logic [1:0]            out_thread_idx;
    logic [LANES-1:0]      out_mask;
    logic [LANES*32-1:0]   out_result;

    modport master (
        output in_valid, in_thread_idx, in_mask, in_sum, in_exponent,
               in_sign, in_is_inf, in_is_nan,
        input  out_valid, out_thread_idx, out_mask, out_result
    );

    modport slave (
        input  in_valid, in_thread_idx, in_mask, in_sum, in_exponent,
               in_sign, in_is_inf, in_is_nan,
        output out_valid, out_thread_idx, out_mask, out_result
    );
endinterface

// File: rtl/fp_normalize_round.sv
// Back end of the multi-cycle FP add path: leading-zero count and exponent
// adjust (stage A), then shift, round-to-nearest-even, special-case override
// and binary32 pack (stage B). Fixed 2-cycle latency, no stall, per-thread
// rollback squash on the input and stage-A slots.
// Optional build macro: FP_FLUSH_TO_ZERO_EN -- results whose exponent field
// stays 0 after rounding are flushed to signed zero instead of being emitted
// as subnormals.
module fp_normalize_round #(
    parameter int LANES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_rollback_en,
    input  logic [1:0]             wb_rollback_thread_idx,
    fp_normalize_round_if.slave    bus
);

    // Leading zeros of a 28-bit magnitude; 28 when the magnitude is zero.
    function automatic logic [4:0] count_lz(input logic [27:0] s);
        logic [4:0] n;
        n = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (s[i]) n = 5'(27 - i);
        end
        return n;
    endfunction

    // Normalize, round to nearest even and apply special-case overrides.
    function automatic logic [31:0] round_pack(
        input logic [27:0]        sum,
        input logic [7:0]         exp_in,
        input logic               sign,
        input logic               is_inf,
        input logic               is_nan,
        input logic [4:0]         lz,
        input logic signed [9:0]  e
    );
        logic [26:0] norm;
        logic [22:0] mant;
        logic [7:0]  exp_field;
        logic        guard;
        logic        sticky;
        logic        round_up;
        logic [30:0] mag;
        logic [31:0] res;
        if (e >= 10'sd1) begin
            norm      = 27'(sum << lz);
            exp_field = e[7:0];
        end else begin
            // Subnormal: align to the fixed minimum exponent instead of fully normalizing.
            norm      = 27'(sum << exp_in);
            exp_field = 8'h00;
        end
        mant     = norm[26:4];
        guard    = norm[3];
        sticky   = |norm[2:0];
        round_up = guard & (sticky | mant[0]);
        // The carry out of the mantissa lands in the exponent field, which
        // promotes subnormals and turns the largest finite value into inf.
        mag      = {exp_field, mant} + 31'(round_up);
        if (is_nan) begin
            res = 32'h7FFF_FFFF;
        end else if (is_inf) begin
            res = {sign, 31'h7F80_0000};
        end else if (sum == 28'h0) begin
            res = {sign, 31'h0};
        end else if (e >= 10'sd255) begin
            res = {sign, 8'hFF, 23'h0};
`ifdef FP_FLUSH_TO_ZERO_EN
        end else if (e <= 10'sd0 && mag[30:23] == 8'h00) begin
            res = {sign, 31'h0};
`endif
        end else begin
            res = {sign, mag};
        end
        return res;
    endfunction

    logic                   squash_in;
    logic                   squash_p1;

    logic [27:0]            sum_a   [LANES];
    logic [4:0]             lz_a    [LANES];
    logic signed [9:0]      e_a     [LANES];

    logic                   vld_p1;
    logic [1:0]             thread_p1;
    logic [LANES-1:0]       mask_p1;
    logic [27:0]            sum_p1  [LANES];
    logic [7:0]             exp_p1  [LANES];
    logic [LANES-1:0]       sign_p1;
    logic [LANES-1:0]       inf_p1;
    logic [LANES-1:0]       nan_p1;
    logic [4:0]             lz_p1   [LANES];
    logic signed [9:0]      e_p1    [LANES];

    logic [31:0]            res_b   [LANES];

    logic                   vld_p2;
    logic [1:0]             thread_p2;
    logic [LANES-1:0]       mask_p2;
    logic [LANES*32-1:0]    result_p2;

    assign squash_in = wb_rollback_en && (bus.in_thread_idx == wb_rollback_thread_idx);
    assign squash_p1 = wb_rollback_en && (thread_p1 == wb_rollback_thread_idx);

    // ---- stage A: leading-zero count and exponent adjust ----

    // Per-lane LZC and adjusted exponent from the raw input beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum_a[l] = bus.in_sum[l*28 +: 28];
            lz_a[l]  = count_lz(sum_a[l]);
            e_a[l]   = $signed({2'b00, bus.in_exponent[l*8 +: 8]}) + 10'sd1
                       - $signed({5'b00000, lz_a[l]});
        end
    end

    // Stage-A register; a beat whose thread is being rolled back is not accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            thread_p1 <= 2'd0;
            mask_p1   <= '0;
            sign_p1   <= '0;
            inf_p1    <= '0;
            nan_p1    <= '0;
            for (int l = 0; l < LANES; l++) begin
                sum_p1[l] <= 28'h0;
                exp_p1[l] <= 8'h0;
                lz_p1[l]  <= 5'd0;
                e_p1[l]   <= 10'sd0;
            end
        end else begin
            vld_p1    <= bus.in_valid && !squash_in;
            thread_p1 <= bus.in_thread_idx;
            mask_p1   <= bus.in_mask;
            sign_p1   <= bus.in_sign;
            inf_p1    <= bus.in_is_inf;
            nan_p1    <= bus.in_is_nan;
            for (int l = 0; l < LANES; l++) begin
                sum_p1[l] <= sum_a[l];
                exp_p1[l] <= bus.in_exponent[l*8 +: 8];
                lz_p1[l]  <= lz_a[l];
                e_p1[l]   <= e_a[l];
            end
        end
    end

    // ---- stage B: shift, round, override, pack ----

    // Every lane is computed regardless of mask.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            res_b[l] = round_pack(sum_p1[l], exp_p1[l], sign_p1[l], inf_p1[l],
                                  nan_p1[l], lz_p1[l], e_p1[l]);
        end
    end

    // Output register; a stage-A beat of the rolled-back thread is dropped here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            thread_p2 <= 2'd0;
            mask_p2   <= '0;
            result_p2 <= '0;
        end else begin
            vld_p2    <= vld_p1 && !squash_p1;
            thread_p2 <= thread_p1;
            mask_p2   <= mask_p1;
            for (int l = 0; l < LANES; l++) begin
                result_p2[l*32 +: 32] <= res_b[l];
            end
        end
    end

    assign bus.out_valid      = vld_p2;
    assign bus.out_thread_idx = thread_p2;
    assign bus.out_mask       = mask_p2;
    assign bus.out_result     = result_p2;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: reset state, 2-cycle latency,
// per-lane rounding/special cases packed into one 16-lane beat, and
// rollback squash scenarios.
module tb_fp_normalize_round;
    localparam int LANES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rb_en;
    logic [1:0]  rb_idx;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_res [LANES];

    fp_normalize_round_if #(.LANES(LANES)) bus ();

    fp_normalize_round #(.LANES(LANES)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .wb_rollback_en         (rb_en),
        .wb_rollback_thread_idx (rb_idx),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [27:0] s, input logic [7:0] e,
                            input logic sg, input logic inf, input logic nan,
                            input logic [31:0] expv);
        bus.in_sum[l*28 +: 28]    = s;
        bus.in_exponent[l*8 +: 8] = e;
        bus.in_sign[l]            = sg;
        bus.in_is_inf[l]          = inf;
        bus.in_is_nan[l]          = nan;
        exp_res[l]                = expv;
    endtask

    task automatic clear_inputs();
        bus.in_valid      = 1'b0;
        bus.in_thread_idx = 2'd0;
        bus.in_mask       = '0;
        bus.in_sum        = '0;
        bus.in_exponent   = '0;
        bus.in_sign       = '0;
        bus.in_is_inf     = '0;
        bus.in_is_nan     = '0;
    endtask

    initial begin
        reset  = 1'b1;
        rb_en  = 1'b0;
        rb_idx = 2'd0;
        clear_inputs();

        // Reset state, even with a beat presented during reset.
        bus.in_valid = 1'b1;
        bus.in_sum   = {LANES{28'h4000000}};
        step();
        step();
        step();
        chk("reset_out_valid",  {31'b0, bus.out_valid}, 32'h0);
        chk("reset_out_thread", {30'b0, bus.out_thread_idx}, 32'h0);
        chk("reset_out_mask",   {16'b0, bus.out_mask}, 32'h0);
        chk("reset_out_lane0",  bus.out_result[31:0], 32'h0);
        clear_inputs();
        reset = 1'b0;
        step();

        // One 16-lane beat of hand-computed cases.
        set_lane(0,  28'h4000000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800000);
        set_lane(1,  28'h8000000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h40000000);
        set_lane(2,  28'h4000004, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800000);
        set_lane(3,  28'h400000C, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800002);
        set_lane(4,  28'h8000000, 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F800000);
        set_lane(5,  28'h1234567, 8'd5,   1'b0, 1'b0, 1'b1, 32'h7FFFFFFF);
        set_lane(6,  28'h0000000, 8'd127, 1'b1, 1'b0, 1'b0, 32'h80000000);
`ifdef FP_FLUSH_TO_ZERO_EN
        set_lane(7,  28'h4000000, 8'd0,   1'b0, 1'b0, 1'b0, 32'h00000000);
        set_lane(10, 28'h0100000, 8'd2,   1'b0, 1'b0, 1'b0, 32'h00000000);
`else
        set_lane(7,  28'h4000000, 8'd0,   1'b0, 1'b0, 1'b0, 32'h00400000);
        set_lane(10, 28'h0100000, 8'd2,   1'b0, 1'b0, 1'b0, 32'h00040000);
`endif
        set_lane(8,  28'h7FFFFFC, 8'd127, 1'b0, 1'b0, 1'b0, 32'h40000000);
        set_lane(9,  28'h7FFFFFC, 8'd0,   1'b0, 1'b0, 1'b0, 32'h00800000);
        set_lane(11, 28'h4000000, 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F000000);
        set_lane(12, 28'h4000000, 8'd10,  1'b1, 1'b1, 1'b0, 32'hFF800000);
        set_lane(13, 28'h4000000, 8'd10,  1'b1, 1'b1, 1'b1, 32'h7FFFFFFF);
        set_lane(14, 28'h4000000, 8'd127, 1'b1, 1'b0, 1'b0, 32'hBF800000);
        set_lane(15, 28'h0000001, 8'd130, 1'b0, 1'b0, 1'b0, 32'h34000000);
        bus.in_valid      = 1'b1;
        bus.in_thread_idx = 2'd2;
        bus.in_mask       = 16'hA5C3;
        step();
        bus.in_valid = 1'b0;
        chk("lat_cycle1_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        chk("lat_cycle2_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("beat_thread",      {30'b0, bus.out_thread_idx}, 32'h2);
        chk("beat_mask",        {16'b0, bus.out_mask}, 32'h0000A5C3);
        for (int l = 0; l < LANES; l++) begin
            chk($sformatf("lane%0d_result", l), bus.out_result[l*32 +: 32], exp_res[l]);
        end
        step();
        chk("lat_cycle3_valid", {31'b0, bus.out_valid}, 32'h0);

        // Threads 0,1,0 back to back; rollback of thread 0 during the second cycle.
        clear_inputs();
        set_lane(0, 28'h4000000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800000);
        bus.in_valid      = 1'b1;
        bus.in_thread_idx = 2'd0;
        step();
        set_lane(0, 28'h4000000, 8'd128, 1'b0, 1'b0, 1'b0, 32'h40000000);
        bus.in_thread_idx = 2'd1;
        rb_en  = 1'b1;
        rb_idx = 2'd0;
        chk("rb_c1_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        set_lane(0, 28'h4000000, 8'd129, 1'b0, 1'b0, 1'b0, 32'h40800000);
        bus.in_thread_idx = 2'd0;
        rb_en = 1'b0;
        chk("rb_c2_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        bus.in_valid = 1'b0;
        chk("rb_c3_valid",  {31'b0, bus.out_valid}, 32'h1);
        chk("rb_c3_thread", {30'b0, bus.out_thread_idx}, 32'h1);
        chk("rb_c3_lane0",  bus.out_result[31:0], 32'h40000000);
        step();
        chk("rb_c4_valid",  {31'b0, bus.out_valid}, 32'h1);
        chk("rb_c4_thread", {30'b0, bus.out_thread_idx}, 32'h0);
        chk("rb_c4_lane0",  bus.out_result[31:0], 32'h40800000);
        step();
        chk("rb_c5_valid",  {31'b0, bus.out_valid}, 32'h0);

        // Rollback in the same cycle as a new beat of that thread drops it.
        bus.in_valid      = 1'b1;
        bus.in_thread_idx = 2'd3;
        rb_en  = 1'b1;
        rb_idx = 2'd3;
        step();
        bus.in_valid = 1'b0;
        rb_en = 1'b0;
        step();
        chk("rb_same_cycle_drop", {31'b0, bus.out_valid}, 32'h0);

        // Rollback of a different thread leaves the stage-A beat alone.
        bus.in_valid      = 1'b1;
        bus.in_thread_idx = 2'd1;
        step();
        bus.in_valid = 1'b0;
        rb_en  = 1'b1;
        rb_idx = 2'd2;
        step();
        rb_en = 1'b0;
        chk("rb_other_thread_valid",  {31'b0, bus.out_valid}, 32'h1);
        chk("rb_other_thread_thread", {30'b0, bus.out_thread_idx}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
